// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*     : EX operand select encodings driven on fwd_a / fwd_b
//   REG_ZERO  : the hard-wired zero register, never a producer
//   slot_t    : one scoreboard slot {dst, wr, ld}
//   make_slot : builds a slot, clearing wr when the destination is $0
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{dst: REG_ZERO, wr: 1'b0, ld: 1'b0};

    // A write to $0 is discarded by the register file, so it must never
    // look like a producer to the hazard logic.
    function automatic slot_t make_slot(logic [4:0] dst, logic wr, logic ld);
        slot_t s;
        s.dst = dst;
        s.wr  = wr && (dst != REG_ZERO);
        s.ld  = ld;
        return s;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives the ID-stage fields and ex_redirect,
//            receives enables, flushes, forwarding selects and counters
//   slave  : controller side (pipe_hazard_ctrl)
interface pipe_hazard_ctrl_if;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_dst;
    logic        id_regwrite;
    logic        id_memtoreg;
    logic        ex_redirect;

    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_memtoreg, ex_redirect,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_memtoreg, ex_redirect,
        output pc_en, if_id_en, if_id_flush, id_ex_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Combinational producer/consumer comparator for one scoreboard slot and
// one source register.
//   slot     : scoreboard slot {dst, wr, ld}
//   src      : source register number being checked
//   use_src  : the consumer actually reads src
//   block_ld : suppress the hit when the slot holds a load
//   hit      : slot produces src for this consumer
module hazard_match
    import pipe_pkg::*;
(
    input  slot_t      slot,
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic       block_ld,
    output logic       hit
);

    assign hit = use_src && slot.wr && (slot.dst == src) && (src != REG_ZERO)
                 && !(block_ld && slot.ld);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Shadows the destinations of the EX, MEM and WB instructions and compares
// them against the ID sources to produce stalls, flushes and forwarding.
//   clk, rst : pipeline clock; synchronous active-high reset
//   bus      : pipe_hazard_ctrl_if.slave (ID fields, ex_redirect in;
//              pc_en, if_id_en, flushes, fwd_a/fwd_b, counters out)
//   FWD_EN   : 1 = forward with load-use stall only,
//              0 = stall until the producer has left WB
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    slot_t       ex_slot;
    slot_t       mem_slot;
    slot_t       wb_slot;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, hit_wb_a, hit_wb_b;
    logic fwd_mem_a, fwd_mem_b, fwd_wb_a, fwd_wb_b;
    logic stall_cond, stall, redirect;

    function automatic logic [15:0] sat_inc(logic [15:0] v, logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    function automatic logic [1:0] fwd_sel(logic mem_hit, logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_RF;
    endfunction

    // ID sources against every in-flight producer
    hazard_match u_ex_a  (.slot(ex_slot),  .src(bus.id_rs), .use_src(bus.id_use_rs), .block_ld(1'b0), .hit(hit_ex_a));
    hazard_match u_ex_b  (.slot(ex_slot),  .src(bus.id_rt), .use_src(bus.id_use_rt), .block_ld(1'b0), .hit(hit_ex_b));
    hazard_match u_mem_a (.slot(mem_slot), .src(bus.id_rs), .use_src(bus.id_use_rs), .block_ld(1'b0), .hit(hit_mem_a));
    hazard_match u_mem_b (.slot(mem_slot), .src(bus.id_rt), .use_src(bus.id_use_rt), .block_ld(1'b0), .hit(hit_mem_b));
    hazard_match u_wb_a  (.slot(wb_slot),  .src(bus.id_rs), .use_src(bus.id_use_rs), .block_ld(1'b0), .hit(hit_wb_a));
    hazard_match u_wb_b  (.slot(wb_slot),  .src(bus.id_rt), .use_src(bus.id_use_rt), .block_ld(1'b0), .hit(hit_wb_b));

    // Registered EX sources against MEM/WB; a load in MEM has no data yet
    hazard_match u_fm_a (.slot(mem_slot), .src(ex_rs), .use_src(1'b1), .block_ld(1'b1), .hit(fwd_mem_a));
    hazard_match u_fm_b (.slot(mem_slot), .src(ex_rt), .use_src(1'b1), .block_ld(1'b1), .hit(fwd_mem_b));
    hazard_match u_fw_a (.slot(wb_slot),  .src(ex_rs), .use_src(1'b1), .block_ld(1'b0), .hit(fwd_wb_a));
    hazard_match u_fw_b (.slot(wb_slot),  .src(ex_rt), .use_src(1'b1), .block_ld(1'b0), .hit(fwd_wb_b));

    assign stall_cond = FWD_EN ? ((hit_ex_a || hit_ex_b) && ex_slot.ld)
                               : (hit_ex_a || hit_ex_b || hit_mem_a ||
                                  hit_mem_b || hit_wb_a || hit_wb_b);

    // Redirect discards the ID instruction, so its hazard is irrelevant.
    // Reset forces the idle output pattern in the reset cycle itself.
    assign redirect = bus.ex_redirect && !rst;
    assign stall    = stall_cond && !redirect && !rst;

    assign bus.pc_en       = !stall;
    assign bus.if_id_en    = !stall;
    assign bus.if_id_flush = redirect;
    assign bus.id_ex_flush = stall || redirect;
    assign bus.fwd_a       = (FWD_EN && !rst) ? fwd_sel(fwd_mem_a, fwd_wb_a) : FWD_RF;
    assign bus.fwd_b       = (FWD_EN && !rst) ? fwd_sel(fwd_mem_b, fwd_wb_b) : FWD_RF;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

    // ID -> EX -> MEM -> WB scoreboard shift
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot     <= SLOT_BUBBLE;
            ex_rs       <= REG_ZERO;
            ex_rt       <= REG_ZERO;
            mem_slot    <= SLOT_BUBBLE;
            wb_slot     <= SLOT_BUBBLE;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall || redirect) begin
                ex_slot <= SLOT_BUBBLE;
                ex_rs   <= REG_ZERO;
                ex_rt   <= REG_ZERO;
            end else begin
                ex_slot <= make_slot(bus.id_dst, bus.id_regwrite, bus.id_memtoreg);
                ex_rs   <= bus.id_rs;
                ex_rt   <= bus.id_rt;
            end
            mem_slot    <= ex_slot;
            wb_slot     <= mem_slot;
            stall_cnt_q <= sat_inc(stall_cnt_q, stall);
            flush_cnt_q <= sat_inc(flush_cnt_q, redirect);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance per FWD_EN setting, both fed the
// same ID-stage stimulus, each checked every cycle against an instruction
// history model, plus literal expectations for the classic hazard cases.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_use_rs = 0, id_use_rt = 0, id_regwrite = 0, id_memtoreg = 0;
    logic       ex_redirect = 0;

    pipe_hazard_ctrl_if bus1();
    pipe_hazard_ctrl_if bus0();

    assign bus1.id_rs = id_rs;             assign bus0.id_rs = id_rs;
    assign bus1.id_rt = id_rt;             assign bus0.id_rt = id_rt;
    assign bus1.id_use_rs = id_use_rs;     assign bus0.id_use_rs = id_use_rs;
    assign bus1.id_use_rt = id_use_rt;     assign bus0.id_use_rt = id_use_rt;
    assign bus1.id_dst = id_dst;           assign bus0.id_dst = id_dst;
    assign bus1.id_regwrite = id_regwrite; assign bus0.id_regwrite = id_regwrite;
    assign bus1.id_memtoreg = id_memtoreg; assign bus0.id_memtoreg = id_memtoreg;
    assign bus1.ex_redirect = ex_redirect; assign bus0.ex_redirect = ex_redirect;

    pipe_hazard_ctrl #(.FWD_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipe_hazard_ctrl #(.FWD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Instructions that entered EX, youngest first: [0]=EX, [1]=MEM, [2]=WB.
    typedef struct {
        logic [4:0] dst;
        bit         wr;
        bit         ld;
        logic [4:0] rs;
        logic [4:0] rt;
    } inst_t;

    inst_t h1[3];
    inst_t h0[3];
    int    c1s, c1f, c0s, c0f;
    bit    mvalid = 0;
    int    cyc = 0;

    function automatic inst_t nop_inst();
        inst_t n;
        n.dst = 0; n.wr = 0; n.ld = 0; n.rs = 0; n.rt = 0;
        return n;
    endfunction

    // An instruction produces r only if it writes a nonzero register r.
    function automatic bit writes(inst_t p, logic [4:0] r);
        return p.wr && p.dst != 0 && p.dst == r;
    endfunction

    function automatic bit id_needs(inst_t p);
        return (id_use_rs && writes(p, id_rs)) || (id_use_rt && writes(p, id_rt));
    endfunction

    function automatic bit m_stall(bit fwd_en, inst_t ex, inst_t mem, inst_t wb);
        if (rst || ex_redirect) return 0;
        if (fwd_en) return ex.ld && id_needs(ex);
        return id_needs(ex) || id_needs(mem) || id_needs(wb);
    endfunction

    function automatic int m_fwd(bit fwd_en, inst_t mem, inst_t wb, logic [4:0] src);
        if (!fwd_en || rst) return 0;
        if (writes(mem, src) && !mem.ld) return 1;
        if (writes(wb, src)) return 2;
        return 0;
    endfunction

    task automatic cmp_dut(input string tag, input bit fwd_en, input inst_t ex, input inst_t mem,
                           input inst_t wb, input int cs, input int cf,
                           input logic pc_en, input logic if_id_en, input logic if_id_flush,
                           input logic id_ex_flush, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [15:0] sc, input logic [15:0] fc);
        bit s, rd;
        string p;
        s  = m_stall(fwd_en, ex, mem, wb);
        rd = ex_redirect && !rst;
        p  = $sformatf("%s cyc%0d ", tag, cyc);
        chk({p, "pc_en"}, pc_en, !s);
        chk({p, "if_id_en"}, if_id_en, !s);
        chk({p, "if_id_flush"}, if_id_flush, rd);
        chk({p, "id_ex_flush"}, id_ex_flush, s || rd);
        chk({p, "fwd_a"}, fa, m_fwd(fwd_en, mem, wb, ex.rs));
        chk({p, "fwd_b"}, fb, m_fwd(fwd_en, mem, wb, ex.rt));
        chk({p, "stall_cnt"}, sc, cs);
        chk({p, "flush_cnt"}, fc, cf);
    endtask

    task automatic advance(input bit fwd_en, inout inst_t ex, inout inst_t mem,
                           inout inst_t wb, inout int cs, inout int cf);
        bit s;
        inst_t n;
        s = m_stall(fwd_en, ex, mem, wb);
        n = nop_inst();
        if (!s && !ex_redirect) begin
            n.dst = id_dst; n.wr = id_regwrite; n.ld = id_memtoreg;
            n.rs = id_rs; n.rt = id_rt;
        end
        wb = mem; mem = ex; ex = n;
        if (s && cs < 65535) cs++;
        if (ex_redirect && cf < 65535) cf++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                cmp_dut("f1", 1'b1, h1[0], h1[1], h1[2], c1s, c1f, bus1.pc_en, bus1.if_id_en,
                        bus1.if_id_flush, bus1.id_ex_flush, bus1.fwd_a, bus1.fwd_b,
                        bus1.stall_cnt, bus1.flush_cnt);
                cmp_dut("f0", 1'b0, h0[0], h0[1], h0[2], c0s, c0f, bus0.pc_en, bus0.if_id_en,
                        bus0.if_id_flush, bus0.id_ex_flush, bus0.fwd_a, bus0.fwd_b,
                        bus0.stall_cnt, bus0.flush_cnt);
            end
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < 3; i++) begin h1[i] = nop_inst(); h0[i] = nop_inst(); end
                c1s = 0; c1f = 0; c0s = 0; c0f = 0;
                mvalid = 1;
            end else if (mvalid) begin
                advance(1'b1, h1[0], h1[1], h1[2], c1s, c1f);
                advance(1'b0, h0[0], h0[1], h0[2], c0s, c0f);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                          input int dst, input bit wr, input bit ld);
        id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_dst = 5'(dst); id_regwrite = wr; id_memtoreg = ld;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; ex_redirect = 0; nop();
        step();
        rst = 0;
    endtask

    initial begin
        int n;
        do_reset();
        #2;
        chk("reset pc_en", bus1.pc_en, 1);
        chk("reset id_ex_flush", bus1.id_ex_flush, 0);
        chk("reset fwd_a", bus1.fwd_a, 0);
        chk("reset stall_cnt", bus0.stall_cnt, 0);

        // lw $8 ; add $9,$8,$10 (forwarding)
        set_id(29, 0, 1, 0, 8, 1, 1);
        step(); set_id(8, 10, 1, 1, 9, 1, 0);
        #2;
        chk("lu pc_en", bus1.pc_en, 0);
        chk("lu id_ex_flush", bus1.id_ex_flush, 1);
        step();
        #2;
        chk("lu released pc_en", bus1.pc_en, 1);
        step(); nop();
        #2;
        chk("lu fwd_a", bus1.fwd_a, 2);
        chk("lu fwd_b", bus1.fwd_b, 0);
        chk("lu stall_cnt", bus1.stall_cnt, 1);

        // add $8 ; sub $9,$8,$8
        do_reset();
        set_id(1, 2, 1, 1, 8, 1, 0);
        step(); set_id(8, 8, 1, 1, 9, 1, 0);
        #2;
        chk("alu no stall", bus1.pc_en, 1);
        step(); nop();
        #2;
        chk("alu fwd_a", bus1.fwd_a, 1);
        chk("alu fwd_b", bus1.fwd_b, 1);
        chk("alu stall_cnt", bus1.stall_cnt, 0);

        // add $8 ; nop ; or $11,$8,$0
        do_reset();
        set_id(1, 2, 1, 1, 8, 1, 0);
        step(); nop();
        step(); set_id(8, 0, 1, 1, 11, 1, 0);
        step(); nop();
        #2;
        chk("wb fwd_a", bus1.fwd_a, 2);
        chk("wb fwd_b zero", bus1.fwd_b, 0);

        // FWD_EN=0: add $8 then use of $8 -> three bubbles
        do_reset();
        set_id(1, 2, 1, 1, 8, 1, 0);
        step(); set_id(8, 0, 1, 0, 9, 1, 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (bus0.pc_en === 1'b0) begin n++; step(); end
            else break;
        end
        chk("nofwd bubbles", n, 3);
        chk("nofwd stall_cnt", bus0.stall_cnt, 3);
        step(); nop();

        // redirect while a load-use hazard is present
        do_reset();
        set_id(29, 0, 1, 0, 8, 1, 1);
        step(); set_id(8, 10, 1, 1, 9, 1, 0); ex_redirect = 1;
        #2;
        chk("rd if_id_flush", bus1.if_id_flush, 1);
        chk("rd id_ex_flush", bus1.id_ex_flush, 1);
        chk("rd pc_en", bus1.pc_en, 1);
        chk("rd if_id_en", bus1.if_id_en, 1);
        step(); ex_redirect = 0; nop();
        #2;
        chk("rd flush_cnt", bus1.flush_cnt, 1);
        chk("rd stall_cnt", bus1.stall_cnt, 0);

        // write $0 then read $0
        do_reset();
        set_id(1, 0, 1, 0, 0, 1, 0);
        step(); set_id(0, 0, 1, 1, 9, 1, 0);
        #2;
        chk("r0 pc_en f1", bus1.pc_en, 1);
        chk("r0 pc_en f0", bus0.pc_en, 1);
        step(); nop();
        #2;
        chk("r0 fwd_a", bus1.fwd_a, 0);
        chk("r0 fwd_b", bus1.fwd_b, 0);

        // reset in the middle of a FWD_EN=0 stall
        do_reset();
        set_id(1, 2, 1, 1, 8, 1, 0);
        step(); set_id(8, 0, 1, 0, 9, 1, 0);
        #2;
        chk("mid stall pc_en", bus0.pc_en, 0);
        step();
        #2;
        chk("mid stall cnt", bus0.stall_cnt, 1);
        rst = 1;
        #1;
        chk("in reset pc_en", bus0.pc_en, 1);
        chk("in reset id_ex_flush", bus0.id_ex_flush, 0);
        step(); rst = 0;
        #2;
        chk("post reset pc_en", bus0.pc_en, 1);
        chk("post reset stall_cnt", bus0.stall_cnt, 0);
        chk("post reset flush_cnt", bus0.flush_cnt, 0);

        // randomized traffic over a small register set to provoke hazards
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) == 0));
            ex_redirect = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 0; ex_redirect = 0;

        // add $8,$8,$8 held in ID: FWD_EN=0 stalls 3 of every 4 cycles
        do_reset();
        set_id(8, 8, 1, 1, 8, 1, 0);
        repeat (87400) step();
        #2;
        chk("sat stall_cnt f0", bus0.stall_cnt, 16'hFFFF);
        chk("sat stall_cnt f1", bus1.stall_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
